dot_accum_mx: RTL and testbench

Streaming MX block-scale accumulator that sits directly downstream of the floating-point dot-product stage. Each accepted beat carries one dot-product result and the two E8M0 shared block scales of the operand blocks that produced it. The block applies the combined scale as a bounded left shift and saturate-adds the aligned term into a wide fixed-point accumulator. On the last beat of a group it emits the accumulated sum, a beat count and sticky exception flags through a valid/ready output.

---
 rtl/dot_accum_mx.sv | 143 ++++++++++++++
 tb/tb_dot_accum_mx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_accum_mx.sv
// dot_accum_mx: MX block-scale accumulator. Each accepted beat carries a
// dot-product result and two E8M0 block scales. The combined scale becomes
// a bounded left shift, and the shifted term is saturate-added into a wide
// fixed-point accumulator. The last beat of a group publishes the sum, the
// beat count and sticky exception flags through a valid/ready output.
module dot_accum_mx #(
  parameter int in_width    = 73,
  parameter int scale_width = 8,
  parameter int scale_bias  = 127,
  parameter int s_min       = -16,
  parameter int s_max       = 16,
  parameter int acc_width   = 128,
  parameter int cnt_width   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [in_width-1:0]  i_dp,
  input  logic [scale_width-1:0]      i_scale_a,
  input  logic [scale_width-1:0]      i_scale_b,
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [acc_width-1:0] o_sum,
  output logic [cnt_width-1:0]        o_count,
  output logic                        o_nan,
  output logic                        o_ovf,
  output logic                        o_unf
);

  // The largest in-range term must fit without wrapping.
  generate
    if (acc_width < in_width + s_max - s_min) begin : g_width_chk
      $error("dot_accum_mx: acc_width too small for in_width + s_max - s_min");
    end
  endgenerate

  localparam int ew = scale_width + 2;
  localparam logic signed [ew-1:0] bias2 = ew'(2 * scale_bias);
  localparam logic signed [ew-1:0] emin  = ew'(s_min);
  localparam logic signed [ew-1:0] emax  = ew'(s_max);
  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};

  // Group state
  logic signed [acc_width-1:0] acc;
  logic [cnt_width-1:0]        cnt;
  logic                        f_nan, f_ovf, f_unf;
  logic                        first;

  // Per-beat datapath
  logic signed [ew-1:0]        e;
  logic [ew-1:0]               sh;
  logic signed [acc_width-1:0] dp_ext;
  logic signed [acc_width-1:0] term;
  logic signed [acc_width-1:0] base;
  logic [acc_width:0]          sum_w;
  logic                        sat;
  logic                        beat_nan, beat_ovf, beat_unf;
  logic signed [acc_width-1:0] acc_nxt;
  logic [cnt_width-1:0]        cnt_nxt;
  logic                        nan_nxt, ovf_nxt, unf_nxt;
  logic                        accept;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  // Scale decode, term alignment and saturating accumulation for the current beat.
  always_comb begin
    e        = $signed({2'b00, i_scale_a}) + $signed({2'b00, i_scale_b}) - bias2;
    sh       = e - emin;
    dp_ext   = {{(acc_width-in_width){i_dp[in_width-1]}}, i_dp};
    beat_nan = (&i_scale_a) || (&i_scale_b);
    beat_ovf = 1'b0;
    beat_unf = 1'b0;
    term     = '0;
    if (beat_nan) begin
      term = '0;
    end else if (e < emin) begin
      beat_unf = 1'b1;
    end else if (e > emax) begin
      if (i_dp != '0) begin
        beat_ovf = 1'b1;
        term     = i_dp[in_width-1] ? acc_min : acc_max;
      end
    end else begin
      term = dp_ext <<< sh;
    end

    base    = first ? '0 : acc;
    // One guard bit: the sum overflowed iff the top two bits disagree.
    sum_w   = {base[acc_width-1], base} + {term[acc_width-1], term};
    sat     = sum_w[acc_width] ^ sum_w[acc_width-1];
    acc_nxt = sat ? (sum_w[acc_width] ? acc_min : acc_max) : sum_w[acc_width-1:0];

    cnt_nxt = first ? cnt_width'(1) : ((&cnt) ? cnt : cnt + 1'b1);
    nan_nxt = (!first && f_nan) || beat_nan;
    ovf_nxt = (!first && f_ovf) || beat_ovf || sat;
    unf_nxt = (!first && f_unf) || beat_unf;
  end

  // Accumulator, beat count and sticky flags advance on every accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      f_nan <= 1'b0;
      f_ovf <= 1'b0;
      f_unf <= 1'b0;
      first <= 1'b1;
    end else if (accept) begin
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      f_nan <= nan_nxt;
      f_ovf <= ovf_nxt;
      f_unf <= unf_nxt;
      first <= i_last;
    end
  end

  // Result registers load on a last beat and hold until the downstream takes them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_count <= '0;
      o_nan   <= 1'b0;
      o_ovf   <= 1'b0;
      o_unf   <= 1'b0;
    end else if (accept && i_last) begin
      o_valid <= 1'b1;
      o_sum   <= acc_nxt;
      o_count <= cnt_nxt;
      o_nan   <= nan_nxt;
      o_ovf   <= ovf_nxt;
      o_unf   <= unf_nxt;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_accum_mx.sv
// Scoreboard bench for dot_accum_mx: a behavioural model computes each group
// result when its last beat is accepted; results are compared as the DUT hands them off.
module tb_dot_accum_mx;

  localparam int IW = 73;
  localparam int AW = 128;
  localparam int CW = 16;
  localparam logic signed [AW+1:0] MAXV = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [AW+1:0] MINV = {3'b111, {(AW-1){1'b0}}};

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic signed [IW-1:0] i_dp = '0;
  logic [7:0]           i_scale_a = '0;
  logic [7:0]           i_scale_b = '0;
  logic                 i_last = 1'b0;
  logic                 o_valid;
  logic                 i_ready = 1'b1;
  logic signed [AW-1:0] o_sum;
  logic [CW-1:0]        o_count;
  logic                 o_nan, o_ovf, o_unf;

  always #5 i_clk = ~i_clk;

  dot_accum_mx #(
    .in_width(IW), .scale_width(8), .scale_bias(127), .s_min(-16), .s_max(16),
    .acc_width(AW), .cnt_width(CW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_dp(i_dp), .i_scale_a(i_scale_a), .i_scale_b(i_scale_b), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_count(o_count),
    .o_nan(o_nan), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  typedef struct {
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          nan, ovf, unf;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model state
  logic                 m_first;
  logic signed [AW+1:0] m_acc;
  logic [CW-1:0]        m_cnt;
  logic                 m_nan, m_ovf, m_unf;

  task automatic model_reset();
    m_first = 1'b1;
    m_acc   = '0;
    m_cnt   = '0;
    m_nan   = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    sb.delete();
  endtask

  task automatic model_beat(input longint dp, input int a, input int b, input logic last);
    int e;
    logic signed [AW+1:0] t, s;
    logic fn, fo, fu;
    res_t r;
    e  = a + b - 254;
    t  = '0;
    fn = 1'b0; fo = 1'b0; fu = 1'b0;
    if (a == 255 || b == 255) fn = 1'b1;
    else if (e < -16) fu = 1'b1;
    else if (e > 16) begin
      if (dp > 0) begin t = MAXV; fo = 1'b1; end
      else if (dp < 0) begin t = MINV; fo = 1'b1; end
    end else begin
      t = (AW+2)'(dp);
      t = t <<< (e + 16);
    end
    s = (m_first ? '0 : m_acc) + t;
    if (s > MAXV) begin s = MAXV; fo = 1'b1; end
    else if (s < MINV) begin s = MINV; fo = 1'b1; end
    m_cnt = m_first ? CW'(1) : ((m_cnt == '1) ? m_cnt : CW'(m_cnt + 1));
    m_nan = (!m_first && m_nan) || fn;
    m_ovf = (!m_first && m_ovf) || fo;
    m_unf = (!m_first && m_unf) || fu;
    m_acc = s;
    if (last) begin
      r.sum = s[AW-1:0];
      r.cnt = m_cnt;
      r.nan = m_nan;
      r.ovf = m_ovf;
      r.unf = m_unf;
      sb.push_back(r);
    end
    m_first = last;
  endtask

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input longint dp, input int a, input int b, input logic last);
    int n;
    n         = 0;
    i_valid   = 1'b1;
    i_dp      = IW'(dp);
    i_scale_a = 8'(a);
    i_scale_b = 8'(b);
    i_last    = last;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("accept_timeout", AW'(o_ready), AW'(1));
    else model_beat(dp, a, b, last);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Output monitor: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge i_clk) begin
    res_t r;
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) chk("unexpected_result", AW'(o_valid), AW'(0));
      else begin
        r = sb.pop_front();
        chk("sum", o_sum, r.sum);
        chk("count", AW'(o_count), AW'(r.cnt));
        chk("nan", AW'(o_nan), AW'(r.nan));
        chk("ovf", AW'(o_ovf), AW'(r.ovf));
        chk("unf", AW'(o_unf), AW'(r.unf));
      end
    end
  end

  always @(posedge i_clk) begin
    if (rnd_rdy) begin
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [AW-1:0] held;
    int n, len, a, b;
    longint d;

    model_reset();
    #12;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_valid", AW'(o_valid), AW'(0));
    chk("rst_ready", AW'(o_ready), AW'(1));
    chk("rst_sum", o_sum, '0);
    chk("rst_count", AW'(o_count), '0);
    chk("rst_flags", AW'({o_nan, o_ovf, o_unf}), '0);
    sync();

    // Unit scales
    beat(5, 127, 127, 1'b0);
    beat(3, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("unit_sum", o_sum, 128'd524288);
    chk("unit_count", AW'(o_count), AW'(2));
    sync();

    // Scale shift and underflow
    beat(-1, 130, 127, 1'b1);
    @(negedge i_clk);
    chk("shift_sum", o_sum, -128'sd524288);
    sync();
    beat(-1, 100, 100, 1'b1);
    @(negedge i_clk);
    chk("unf_sum", o_sum, '0);
    chk("unf_flag", AW'(o_unf), AW'(1));
    sync();

    // Overflow: out-of-range exponent, then saturating adds both ways
    beat(1, 200, 127, 1'b1);
    @(negedge i_clk);
    chk("ovf_sum", o_sum, {1'b0, {(AW-1){1'b1}}});
    chk("ovf_flag", AW'(o_ovf), AW'(1));
    sync();
    beat(7, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("ovf_cleared", AW'(o_ovf), AW'(0));
    sync();
    beat(1, 200, 127, 1'b0);
    beat(1, 127, 127, 1'b1);
    beat(-1, 200, 127, 1'b0);
    beat(-1, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("neg_sat_sum", o_sum, {1'b1, {(AW-1){1'b0}}});
    sync();

    // NaN on a middle beat
    beat(10, 127, 127, 1'b0);
    beat(20, 255, 127, 1'b0);
    beat(30, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("nan_flag", AW'(o_nan), AW'(1));
    chk("nan_sum", o_sum, 128'd2621440);
    sync();
    beat(1, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("nan_cleared", AW'(o_nan), AW'(0));
    sync();

    // Back-to-back single-beat groups
    for (int i = 0; i < 4; i++) beat(longint'(i + 1), 127, 128, 1'b1);
    sync();
    sync();

    // Backpressure with a same-cycle last beat on release
    i_ready = 1'b0;
    beat(9, 127, 127, 1'b1);
    fork
      beat(11, 127, 127, 1'b1);
      begin
        held = o_sum;
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clk);
          chk("stall_ready", AW'(o_ready), AW'(0));
          chk("stall_sum", o_sum, held);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("stay_valid", AW'(o_valid), AW'(1));
      end
    join
    sync();
    sync();

    // Asynchronous reset mid-group
    beat(100, 127, 127, 1'b0);
    beat(200, 127, 127, 1'b0);
    #3;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_sum", o_sum, '0);
    chk("arst_valid", AW'(o_valid), AW'(0));
    chk("arst_count", AW'(o_count), '0);
    #2;
    i_rst_n = 1'b1;
    sync();
    beat(4, 127, 127, 1'b1);
    @(negedge i_clk);
    chk("post_rst_sum", o_sum, 128'd262144);
    chk("post_rst_count", AW'(o_count), AW'(1));
    sync();

    // Random groups under random downstream backpressure
    rnd_rdy = 1'b1;
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        d = longint'({$urandom, $urandom});
        a = ($urandom_range(0, 11) == 0) ? 255 : $urandom_range(115, 140);
        b = $urandom_range(115, 140);
        beat(d, a, b, k == len - 1);
      end
    end
    rnd_rdy = 1'b0;
    sync();
    i_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", AW'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
